display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 N_REQ, 3: number of requesters sharing the 4-digit display.
REQ-002 STEP_CYCLES, 65536: clocks per luminance step during fades; legal range is 1 or greater.
REQ-003 DWELL_CYCLES, 2^24: minimum SHOW clocks before a pending competitor preempts the owner; legal range is 1 or greater.
REQ-004 LUM_MAX, 15: full-brightness luminance code; legal range is 1..15.

Ports (name, direction, width, meaning):
REQ-005 clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 rst, input, 1: asynchronous, active-high reset.
REQ-007 req, input, N_REQ: per-requester level request for the display.
REQ-008 hexx_in, input, N_REQ*16: per-requester 4 hex digits; requester k occupies bits [16k+15:16k].
REQ-009 points_in, input, N_REQ*4: per-requester decimal points; requester k occupies bits [4k+3:4k].
REQ-010 grant, output, N_REQ: one-hot current owner, or all zero when there is no owner.
REQ-011 en, output, 1: display enable, high whenever grant is nonzero.
REQ-012 luminance, output, 4: brightness code for the display driver.
REQ-013 hexx, output, 16: digits of the owner, registered.
REQ-014 points, output, 4: decimal points of the owner, registered.
REQ-015 busy, output, 1: high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, FADE_IN, SHOW and FADE_OUT; each state change SHALL take effect on the clock edge after its condition is true.
REQ-017 In IDLE with any req bit high, the block SHALL select the first set bit searching ptr, ptr+1, ... modulo N_REQ.
REQ-018 On that selection it SHALL set grant to the selected one-hot value, set en to 1, set luminance to 0 and move to FADE_IN.
REQ-019 In FADE_IN, luminance SHALL increment once every STEP_CYCLES clocks.
REQ-020 When luminance reaches LUM_MAX in FADE_IN, the block SHALL move to SHOW and clear the dwell counter.
REQ-021 In SHOW, luminance SHALL hold at LUM_MAX and the dwell counter SHALL increment every clock, saturating at DWELL_CYCLES.
REQ-022 The block SHALL leave SHOW for FADE_OUT when the owner's req falls.
REQ-023 The block SHALL also leave SHOW for FADE_OUT when dwell is at least DWELL_CYCLES and any other req bit is high.
REQ-024 With no competitor pending, the owner SHALL hold the display indefinitely.
REQ-025 If the owner's req falls during FADE_IN, the block SHALL go to FADE_OUT starting from the current luminance.
REQ-026 In FADE_OUT, luminance SHALL decrement once every STEP_CYCLES clocks.
REQ-027 When luminance reaches 0 in FADE_OUT, the block SHALL clear grant and en, set ptr to (owner+1) mod N_REQ, and move to IDLE.
REQ-028 In FADE_OUT, owner req reassertion and new requests SHALL be ignored until IDLE is reached.
REQ-029 While granted, hexx and points SHALL equal the owner's hexx_in and points_in sampled on the previous clock (one-cycle latency).
REQ-030 In IDLE, hexx and points SHALL be 0.
REQ-031 The step counter SHALL clear on every state entry, so the first step occurs exactly STEP_CYCLES clocks after entry; STEP_CYCLES=1 steps every clock.
REQ-032 Luminance SHALL never exceed LUM_MAX and SHALL never underflow below 0.
REQ-033 The step counter width SHALL be $clog2(STEP_CYCLES+1) and the dwell counter width SHALL be $clog2(DWELL_CYCLES+1).

Reset
REQ-034 While rst is high, the block SHALL hold state=IDLE, ptr=0, grant=0, en=0, busy=0, luminance=0, hexx=0, points=0, and both counters at 0.
REQ-035 Reset asserted mid-operation, including in SHOW, SHALL force these values immediately without waiting for a clock edge.

Structure
REQ-036 Package display_pkg SHALL hold the FSM state enum, the luminance width constant (4) and the digit width constant (16).
REQ-037 Sub-module display_lum_ramp SHALL contain the step counter and the up/down/hold luminance register with saturation flags; the FSM and round-robin selection SHALL stay in display_arbiter.

Verification (STEP_CYCLES=2, DWELL_CYCLES=8, LUM_MAX=15 unless stated)
REQ-038 Held req=001 after reset -> grant=001 one clock later; luminance=15 after a further 30 clocks; held indefinitely.
REQ-039 req=101 from IDLE with ptr=0 -> requester 0 owns; FADE_OUT starts 8 SHOW clocks later; grant=100 one clock after luminance returns to 0.
REQ-040 After requester 1 is served, with req=111 -> grant=100.
REQ-041 Owner req drops at luminance=5 in FADE_IN -> luminance reaches 0 in 10 clocks, then grant=000.
REQ-042 hexx_in for requester 1 = 16'hBEEF and points_in for requester 1 = 4'b1010 while grant=010 -> hexx=BEEF and points=1010 one clock later.
REQ-043 rst pulsed mid-SHOW -> all outputs 0 before the next clock edge; with req still high, re-arbitration starts from ptr=0 after rst releases.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and widths for the display arbiter and its luminance ramp.
package display_pkg;
  localparam int LUM_W   = 4;
  localparam int DIGIT_W = 16;

  typedef enum logic [1:0] {IDLE, FADE_IN, SHOW, FADE_OUT} state_t;
endpackage

// File: rtl/display_lum_ramp.sv
// Luminance register stepped up or down once every STEP_CYCLES clocks, with
// saturation flags at 0 and LUM_MAX.
module display_lum_ramp
  import display_pkg::*;
#(
  parameter int STEP_CYCLES = 65536,
  parameter int LUM_MAX     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             zero,
  input  logic             up,
  input  logic             down,
  output logic [LUM_W-1:0] lum,
  output logic             at_max,
  output logic             at_zero
);
  localparam int SC_W = $clog2(STEP_CYCLES + 1);
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_CYCLES - 1);

  logic [SC_W-1:0] cnt;

  assign at_max  = (lum >= LUM_W'(LUM_MAX));
  assign at_zero = (lum == '0);

  // clr marks a state entry: the step phase restarts and luminance holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      lum <= '0;
    end else if (clr) begin
      cnt <= '0;
      if (zero) lum <= '0;
    end else if (up || down) begin
      if (cnt == STEP_LAST) begin
        cnt <= '0;
        if (up && !at_max)        lum <= lum + 1'b1;
        else if (down && !at_zero) lum <= lum - 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of a shared 4-digit display with fade-in / show / fade-out
// sequencing and dwell-based preemption.
module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int STEP_CYCLES  = 65536,
  parameter int DWELL_CYCLES = 2**24,
  parameter int LUM_MAX      = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DIGIT_W-1:0] hexx_in,
  input  logic [N_REQ*4-1:0]       points_in,
  output logic [N_REQ-1:0]         grant,
  output logic                     en,
  output logic [LUM_W-1:0]         luminance,
  output logic [DIGIT_W-1:0]       hexx,
  output logic [3:0]               points,
  output logic                     busy
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_CYCLES);

  state_t state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt, ptr, ptr_nxt, sel;
  logic [DW_W-1:0]  dwell;
  logic [N_REQ-1:0] owner_hot;
  logic ramp_clr, ramp_zero, ramp_up, ramp_dn, dwell_clr, at_max, at_zero, found;
  int   idx;

  logic [N_REQ-1:0][DIGIT_W-1:0] hex_arr;
  logic [N_REQ-1:0][3:0]         pts_arr;
  assign hex_arr = hexx_in;
  assign pts_arr = points_in;

  assign owner_hot = N_REQ'(1) << owner;
  assign busy      = (state != IDLE);
  assign grant     = busy ? owner_hot : '0;
  assign en        = |grant;

  display_lum_ramp #(.STEP_CYCLES(STEP_CYCLES), .LUM_MAX(LUM_MAX)) u_ramp (
    .clk(clk), .rst(rst), .clr(ramp_clr), .zero(ramp_zero), .up(ramp_up),
    .down(ramp_dn), .lum(luminance), .at_max(at_max), .at_zero(at_zero)
  );

  // First requester at or after ptr, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    ramp_clr  = 1'b0;
    ramp_zero = 1'b0;
    ramp_up   = 1'b0;
    ramp_dn   = 1'b0;
    dwell_clr = 1'b0;
    case (state)
      IDLE: if (found) begin
        owner_nxt = sel;
        state_nxt = FADE_IN;
        ramp_clr  = 1'b1;
        ramp_zero = 1'b1;
      end
      FADE_IN: begin
        if (!req[owner]) begin
          state_nxt = FADE_OUT;
          ramp_clr  = 1'b1;
        end else if (at_max) begin
          state_nxt = SHOW;
          ramp_clr  = 1'b1;
          dwell_clr = 1'b1;
        end else begin
          ramp_up = 1'b1;
        end
      end
      SHOW: if (!req[owner] || (dwell >= DWELL_MAX && |(req & ~owner_hot))) begin
        state_nxt = FADE_OUT;
        ramp_clr  = 1'b1;
      end
      FADE_OUT: begin
        if (at_zero) begin
          state_nxt = IDLE;
          ramp_clr  = 1'b1;
          ptr_nxt   = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end else begin
          ramp_dn = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digits are captured with the next owner so they track grant with one clock of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      ptr    <= '0;
      dwell  <= '0;
      hexx   <= '0;
      points <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      if (dwell_clr)                              dwell <= '0;
      else if (state == SHOW && dwell < DWELL_MAX) dwell <= dwell + 1'b1;
      if (state_nxt != IDLE) begin
        hexx   <= hex_arr[owner_nxt];
        points <= pts_arr[owner_nxt];
      end else begin
        hexx   <= '0;
        points <= '0;
      end
    end
  end
endmodule

// File: tb/tb_display_arbiter.sv
// Randomized bench for display_arbiter against a time-since-entry reference model.
module tb_display_arbiter;
  localparam int N     = 3;
  localparam int STEP  = 2;
  localparam int DWELL = 8;
  localparam int LMAX  = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*16-1:0] hexx_in = '0;
  logic [N*4-1:0] points_in = '0;
  logic [N-1:0]   grant;
  logic           en, busy;
  logic [3:0]     luminance, points;
  logic [15:0]    hexx;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 fade-in, 2 show, 3 fade-out; m_t counts edges since entry.
  int m_phase, m_owner, m_ptr, m_t, m_base, m_hex, m_pts;

  display_arbiter #(.N_REQ(N), .STEP_CYCLES(STEP), .DWELL_CYCLES(DWELL), .LUM_MAX(LMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .hexx_in(hexx_in), .points_in(points_in),
    .grant(grant), .en(en), .luminance(luminance), .hexx(hexx), .points(points), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_lum();
    int v;
    case (m_phase)
      1: begin v = m_t / STEP; return (v > LMAX) ? LMAX : v; end
      2: return LMAX;
      3: begin v = m_base - m_t / STEP; return (v < 0) ? 0 : v; end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_t = 0; m_base = 0; m_hex = 0; m_pts = 0;
  endtask

  task automatic model_step();
    int cur;
    bit others;
    cur = m_lum();
    others = ((req & ~(N'(1) << m_owner)) != 0);
    case (m_phase)
      0: if (req != 0) begin
        for (int i = N - 1; i >= 0; i--)
          if (req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
        m_phase = 1; m_t = 0;
      end
      1: if (!req[m_owner]) begin m_base = cur; m_phase = 3; m_t = 0; end
         else if (cur == LMAX) begin m_phase = 2; m_t = 0; end
         else m_t++;
      2: if (!req[m_owner] || (m_t >= DWELL && others)) begin m_base = LMAX; m_phase = 3; m_t = 0; end
         else m_t++;
      3: if (cur == 0) begin m_phase = 0; m_ptr = (m_owner + 1) % N; end
         else m_t++;
      default: m_phase = 0;
    endcase
    m_hex = (m_phase != 0) ? int'(hexx_in[16*m_owner +: 16]) : 0;
    m_pts = (m_phase != 0) ? int'(points_in[4*m_owner +: 4]) : 0;
  endtask

  task automatic check_all();
    chk("grant", 32'(grant), (m_phase != 0) ? (32'd1 << m_owner) : 32'd0);
    chk("en", 32'(en), 32'(m_phase != 0));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("luminance", 32'(luminance), m_lum());
    chk("hexx", 32'(hexx), m_hex);
    chk("points", 32'(points), m_pts);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    model_reset();
    hexx_in   = {16'hC0DE, 16'hBEEF, 16'h0A0A};
    points_in = {4'h3, 4'b1010, 4'h5};
    run(3);
    rst = 1'b0;

    req = 3'b001; run(60);
    req = 3'b101; run(120);
    req = 3'b010; run(120);
    req = 3'b111; run(150);

    // Owner drops mid fade-in at luminance 5.
    req = 3'b000;
    n = 0;
    while (m_phase != 0 && n < 200) begin tick(); n++; end
    chk("wait_idle", 32'(n < 200), 32'd1);
    req = 3'b001;
    n = 0;
    while (!(m_phase == 1 && m_lum() == 5) && n < 200) begin tick(); n++; end
    chk("wait_lum5", 32'(n < 200), 32'd1);
    req = 3'b000; run(20);

    // Asynchronous reset while showing.
    req = 3'b011;
    n = 0;
    while (m_phase != 2 && n < 200) begin tick(); n++; end
    chk("wait_show", 32'(n < 200), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_lum", 32'(luminance), 32'd0);
    chk("arst_hexx", 32'(hexx), 32'd0);
    chk("arst_points", 32'(points), 32'd0);
    model_reset();
    run(2);
    rst = 1'b0;
    run(60);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) req = N'($urandom_range(7));
      hexx_in   = {$urandom, $urandom};
      points_in = N*4'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
